// File: rtl/axi_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arb_pkg
//  Description : Shared constants and helpers for the two-port AXI read arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_rd_arb_pkg;

    localparam logic       SEL_DISPLAY    = 1'b0;
    localparam logic       SEL_GENERIC    = 1'b1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Bits needed to hold 0..max_out inclusive.
    function automatic int outstanding_cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_outstanding_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_outstanding_cnt
//  Description : Saturating count of accepted-but-not-completed read bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rd_outstanding_cnt
    import axi_rd_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic aclk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam int               C_CNT_W = outstanding_cnt_width(MAX);
    localparam logic [C_CNT_W-1:0] C_MAX = C_CNT_W'(MAX);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (inc && !dec && !full) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && !empty) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign full  = (r_count == C_MAX);
    assign empty = (r_count == '0);

    // A completion with nothing outstanding means an upstream protocol violation.
    a_no_underflow : assert property (@(posedge aclk) disable iff (!resetn) !(dec && empty));

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rd_arbiter
//  Description : Fixed-priority AXI4 read arbiter (display over generic) with
//                anti-starvation and per-requester outstanding-burst caps.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                  aclk,
    input  logic                  resetn,
    // slave 0 (display)
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [ID_WIDTH-1:0]   s0_rid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    // slave 1 (generic)
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [ID_WIDTH-1:0]   s1_rid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    // master
    output logic [ID_WIDTH:0]     m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH:0]     m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int                    C_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_STARVE_W-1:0] C_STARVE_MAX = C_STARVE_W'(STARVE_LIMIT);

    logic                  w_slot_free;
    logic                  w_elig0, w_elig1;
    logic                  w_s1_wins;
    logic                  w_grant0, w_grant1;
    logic                  w_full0, w_full1;
    logic                  w_empty0, w_empty1;
    logic                  w_inc0, w_inc1;
    logic                  w_dec0, w_dec1;
    logic                  w_sel;
    logic [C_STARVE_W-1:0] r_starve;

    // ------------------------------------------------------------------ AR
    assign w_slot_free = !m_arvalid || m_arready;
    assign w_elig0     = s0_arvalid && !w_full0;
    assign w_elig1     = s1_arvalid && !w_full1;
    assign w_s1_wins   = w_elig1 && (!w_elig0 || (r_starve == C_STARVE_MAX));

    // Gated by resetn so neither requester sees a handshake while reset is held.
    assign w_grant1 = resetn && w_slot_free && w_s1_wins;
    assign w_grant0 = resetn && w_slot_free && w_elig0 && !w_s1_wins;

    assign s0_arready = w_grant0;
    assign s1_arready = w_grant1;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            m_arvalid <= 1'b0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
        end else if (w_slot_free) begin
            m_arvalid <= w_grant0 || w_grant1;
            if (w_grant1) begin
                m_arid    <= {SEL_GENERIC, s1_arid};
                m_araddr  <= s1_araddr;
                m_arlen   <= s1_arlen;
                m_arsize  <= s1_arsize;
                m_arburst <= s1_arburst;
            end else if (w_grant0) begin
                m_arid    <= {SEL_DISPLAY, s0_arid};
                m_araddr  <= s0_araddr;
                m_arlen   <= s0_arlen;
                m_arsize  <= s0_arsize;
                m_arburst <= s0_arburst;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_starve <= '0;
        end else if (w_grant1) begin
            r_starve <= '0;
        end else if (w_grant0 && w_elig1 && (r_starve != C_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------- R
    assign w_sel     = m_rid[ID_WIDTH];
    assign s0_rvalid = m_rvalid && (w_sel == SEL_DISPLAY);
    assign s1_rvalid = m_rvalid && (w_sel == SEL_GENERIC);
    assign s0_rid    = m_rid[ID_WIDTH-1:0];
    assign s1_rid    = m_rid[ID_WIDTH-1:0];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;
    assign m_rready  = w_sel ? s1_rready : s0_rready;

    // ---------------------------------------------------------- outstanding
    assign w_inc0 = s0_arvalid && s0_arready;
    assign w_inc1 = s1_arvalid && s1_arready;
    assign w_dec0 = m_rvalid && m_rready && m_rlast && (w_sel == SEL_DISPLAY);
    assign w_dec1 = m_rvalid && m_rready && m_rlast && (w_sel == SEL_GENERIC);

    axi_rd_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt0 (
        .aclk   (aclk),
        .resetn (resetn),
        .inc    (w_inc0),
        .dec    (w_dec0),
        .full   (w_full0),
        .empty  (w_empty0)
    );

    axi_rd_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt1 (
        .aclk   (aclk),
        .resetn (resetn),
        .inc    (w_inc1),
        .dec    (w_dec1),
        .full   (w_full1),
        .empty  (w_empty1)
    );

    a_one_ready : assert property (@(posedge aclk) !(s0_arready && s1_arready));
    a_cnt_bounds : assert property (@(posedge aclk) disable iff (!resetn)
        !(w_inc0 && w_full0) && !(w_inc1 && w_full1) && !(w_dec0 && w_empty0) && !(w_dec1 && w_empty1));

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rd_arbiter
//  Description : Directed self-checking bench for axi_rd_arbiter with a
//                cycle-level reference model and R-channel scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_rd_arbiter;
    import axi_rd_arb_pkg::*;

    localparam int AW = 32, DW = 32, IW = 4, MAXO = 4, SLIM = 8;

    logic          aclk = 1'b0, resetn = 1'b0;
    logic [IW-1:0] s0_arid = '0, s1_arid = '0;
    logic [AW-1:0] s0_araddr = '0, s1_araddr = '0;
    logic [7:0]    s0_arlen = '0, s1_arlen = '0;
    logic [2:0]    s0_arsize = '0, s1_arsize = '0;
    logic [1:0]    s0_arburst = '0, s1_arburst = '0;
    logic          s0_arvalid = 1'b0, s1_arvalid = 1'b0;
    logic          s0_arready, s1_arready;
    logic [IW-1:0] s0_rid, s1_rid;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic [1:0]    s0_rresp, s1_rresp;
    logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
    logic          s0_rready = 1'b0, s1_rready = 1'b0;
    logic [IW:0]   m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [IW:0]   m_rid = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = '0;
    logic          m_rlast = 1'b0, m_rvalid = 1'b0;
    logic          m_rready;

    always #5 aclk = ~aclk;

    axi_rd_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)
    ) dut (
        .aclk(aclk), .resetn(resetn),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------------------------------------------------------- model
    int          mdl_cnt[2];
    int          mdl_starve;
    bit          mdl_avalid;
    logic [IW:0] mdl_aid;
    logic [AW-1:0] mdl_aaddr;
    logic [7:0]  mdl_alen;
    logic [2:0]  mdl_asize;
    logic [1:0]  mdl_aburst;
    bit          mdl_live = 1'b0;

    // Which requester the rules say wins this cycle: -1 none, 0 or 1.
    function automatic int model_winner();
        bit e0, e1;
        if (!resetn) return -1;
        if (mdl_avalid && !m_arready) return -1;
        e0 = s0_arvalid && (mdl_cnt[0] < MAXO);
        e1 = s1_arvalid && (mdl_cnt[1] < MAXO);
        if (e1 && (!e0 || mdl_starve == SLIM)) return 1;
        if (e0) return 0;
        return -1;
    endfunction

    initial begin
        int w;
        bit e1, rsel, rdone, inc, dec;
        forever begin
            @(posedge aclk);
            w = model_winner();
            if (!resetn) begin
                mdl_cnt[0] = 0; mdl_cnt[1] = 0; mdl_starve = 0;
                mdl_avalid = 1'b0; mdl_aid = '0; mdl_aaddr = '0;
                mdl_alen = '0; mdl_asize = '0; mdl_aburst = '0;
                mdl_live = 1'b1;
            end else begin
                rsel  = m_rid[IW];
                rdone = m_rvalid && m_rlast && (rsel ? s1_rready : s0_rready);
                e1    = s1_arvalid && (mdl_cnt[1] < MAXO);
                if (!mdl_avalid || m_arready) begin
                    mdl_avalid = (w >= 0);
                    if (w == 1) begin
                        mdl_aid = {1'b1, s1_arid}; mdl_aaddr = s1_araddr; mdl_alen = s1_arlen;
                        mdl_asize = s1_arsize; mdl_aburst = s1_arburst;
                    end else if (w == 0) begin
                        mdl_aid = {1'b0, s0_arid}; mdl_aaddr = s0_araddr; mdl_alen = s0_arlen;
                        mdl_asize = s0_arsize; mdl_aburst = s0_arburst;
                    end
                end
                if (w == 1) mdl_starve = 0;
                else if (w == 0 && e1 && mdl_starve < SLIM) mdl_starve++;
                for (int x = 0; x < 2; x++) begin
                    inc = (w == x);
                    dec = rdone && (int'(rsel) == x);
                    if (inc && !dec) mdl_cnt[x]++;
                    else if (dec && !inc && mdl_cnt[x] > 0) mdl_cnt[x]--;
                end
            end
        end
    end

    // Cycle compare of every output against the model.
    initial begin
        int w;
        forever begin
            @(negedge aclk);
            if (mdl_live) begin
                w = model_winner();
                check("s0_arready", s0_arready, w == 0);
                check("s1_arready", s1_arready, w == 1);
                check("m_arvalid", m_arvalid, mdl_avalid);
                if (mdl_avalid) begin
                    check("m_arid", m_arid, mdl_aid);
                    check("m_araddr", m_araddr, mdl_aaddr);
                    check("m_arlen", m_arlen, mdl_alen);
                    check("m_arsize", m_arsize, mdl_asize);
                    check("m_arburst", m_arburst, mdl_aburst);
                end
                check("s0_rvalid", s0_rvalid, m_rvalid && !m_rid[IW]);
                check("s1_rvalid", s1_rvalid, m_rvalid && m_rid[IW]);
                check("m_rready", m_rready, m_rid[IW] ? s1_rready : s0_rready);
                if (m_rvalid) begin
                    check("rx_rid", {s1_rid, s0_rid}, {m_rid[IW-1:0], m_rid[IW-1:0]});
                    check("rx_rdata", {s1_rdata, s0_rdata}, {m_rdata, m_rdata});
                    check("rx_rresp_rlast", {s1_rresp, s1_rlast, s0_rresp, s0_rlast},
                          {m_rresp, m_rlast, m_rresp, m_rlast});
                end
            end
        end
    end

    // R scoreboard: beats actually handed to each slave.
    bit            sb_on = 1'b0;
    logic [DW-1:0] got0[$], got1[$], exp0[$], exp1[$];
    initial forever begin
        @(negedge aclk);
        if (sb_on && s0_rvalid && s0_rready) got0.push_back(s0_rdata);
        if (sb_on && s1_rvalid && s1_rready) got1.push_back(s1_rdata);
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- tasks
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_ar(input int s, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len);
        if (s == 0) begin
            s0_arid = id; s0_araddr = addr; s0_arlen = len;
            s0_arsize = 3'd2; s0_arburst = AXI_BURST_INCR; s0_arvalid = 1'b1;
        end else begin
            s1_arid = id; s1_araddr = addr; s1_arlen = len;
            s1_arsize = 3'd2; s1_arburst = AXI_BURST_INCR; s1_arvalid = 1'b1;
        end
    endtask

    task automatic r_beat(input logic sel, input logic [IW-1:0] id, input logic [DW-1:0] data,
                          input logic last);
        m_rvalid = 1'b1; m_rid = {sel, id}; m_rdata = data;
        m_rresp = data[1:0]; m_rlast = last;
    endtask

    task automatic r_idle();
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int n, prev, g;
        int seq[$];

        repeat (2) tick();
        resetn = 1'b1;
        @(negedge aclk);
        check("rst_m_arvalid", m_arvalid, 0);
        check("rst_m_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst}, 0);
        check("rst_cnt", {dut.u_cnt0.r_count, dut.u_cnt1.r_count}, 0);
        check("rst_starve", dut.r_starve, 0);
        tick();

        // single requester, 16-beat burst
        m_arready = 1'b1;
        set_ar(0, 4'd3, 32'h01E0_0000, 8'd15);
        @(negedge aclk);
        check("t1_s0_arready", s0_arready, 1);
        tick();
        s0_arvalid = 1'b0;
        @(negedge aclk);
        check("t1_m_arvalid", m_arvalid, 1);
        check("t1_m_arid", m_arid, 5'b00011);
        check("t1_m_araddr", m_araddr, 32'h01E0_0000);
        check("t1_m_arlen", m_arlen, 8'd15);
        check("t1_cnt0_busy", dut.u_cnt0.r_count, 1);
        tick();
        s0_rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r_beat(1'b0, 4'd3, 32'hD000_0000 + i, i == 15);
            @(negedge aclk);
            check("t1_beat_route", {s1_rvalid, s0_rvalid}, 2'b01);
            tick();
        end
        r_idle();
        @(negedge aclk);
        check("t1_cnt0_done", dut.u_cnt0.r_count, 0);
        tick();

        // outstanding cap on s1
        set_ar(1, 4'd5, 32'h8000_0000, 8'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (s1_arready) n++;
            tick();
        end
        check("t3_accepted", n, 4);
        s1_rready = 1'b1;
        r_beat(1'b1, 4'd5, 32'hC0DE_0001, 1'b1);
        @(negedge aclk);
        check("t3_still_full", s1_arready, 0);
        tick();
        r_idle();
        @(negedge aclk);
        check("t3_reaccept", s1_arready, 1);
        tick();
        s1_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_beat(1'b1, 4'd5, 32'hC0DE_0010 + i, 1'b1);
            tick();
        end
        r_idle();
        @(negedge aclk);
        check("t3_cnt1_drained", dut.u_cnt1.r_count, 0);
        tick();

        // contention: 8 x s0 then 1 x s1, single-beat bursts returned promptly
        s0_rready = 1'b1; s1_rready = 1'b1;
        set_ar(0, 4'd3, 32'h0100_0000, 8'd0);
        set_ar(1, 4'd5, 32'h0200_0000, 8'd0);
        prev = -1;
        for (int i = 0; i < 20; i++) begin
            if (prev < 0) r_idle();
            else r_beat(prev[0], (prev == 1) ? 4'd5 : 4'd3, 32'h5000_0000 + i, 1'b1);
            @(negedge aclk);
            g = s1_arready ? 1 : (s0_arready ? 0 : -1);
            seq.push_back(g);
            prev = g;
            tick();
        end
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        r_beat(prev[0], (prev == 1) ? 4'd5 : 4'd3, 32'h5000_00FF, 1'b1);
        tick();
        r_idle();
        for (int i = 0; i < 20; i++)
            check("t2_grant_order", seq[i], (i % 9 == 8) ? 1 : 0);
        @(negedge aclk);
        check("t2_cnt_idle", {dut.u_cnt0.r_count, dut.u_cnt1.r_count}, 0);
        check("t2_starve_tail", dut.r_starve, 2);
        tick();

        // backpressure on the master AR slot
        m_arready = 1'b0;
        set_ar(0, 4'd7, 32'h0300_0000, 8'd3);
        @(negedge aclk);
        check("t4_first_accept", s0_arready, 1);
        tick();
        set_ar(0, 4'd8, 32'h0400_0000, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("t4_hold", {m_arvalid, m_arid, m_araddr, s0_arready},
                  {1'b1, 5'b00111, 32'h0300_0000, 1'b0});
            tick();
        end
        m_arready = 1'b1;
        @(negedge aclk);
        check("t4_same_cycle_accept", s0_arready, 1);
        tick();
        s0_arvalid = 1'b0; m_arready = 1'b0;
        @(negedge aclk);
        check("t4_second_payload", {m_arvalid, m_arid, m_araddr}, {1'b1, 5'b01000, 32'h0400_0000});
        check("t4_cnt0", dut.u_cnt0.r_count, 2);
        check("t4_starve_held", dut.r_starve, 2);
        tick();

        // reset with traffic outstanding
        resetn = 1'b0; s0_arvalid = 1'b1; s1_arvalid = 1'b1;
        @(negedge aclk);
        check("t6_arready_in_reset", {s0_arready, s1_arready}, 2'b00);
        tick();
        resetn = 1'b1; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        @(negedge aclk);
        check("t6_m_arvalid", m_arvalid, 0);
        check("t6_cnt", {dut.u_cnt0.r_count, dut.u_cnt1.r_count}, 0);
        check("t6_starve", dut.r_starve, 0);
        tick();

        // interleaved R with s1 back-pressured
        m_arready = 1'b1;
        set_ar(0, 4'd2, 32'h0500_0000, 8'd3);
        tick();
        s0_arvalid = 1'b0;
        set_ar(1, 4'd6, 32'h0600_0000, 8'd3);
        tick();
        s1_arvalid = 1'b0;
        tick();
        sb_on = 1'b1; s0_rready = 1'b1; s1_rready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            logic [DW-1:0] d;
            d = (b % 2 == 1) ? (32'hB100_0000 + b / 2) : (32'hA000_0000 + b / 2);
            if (b % 2 == 1) exp1.push_back(d); else exp0.push_back(d);
            r_beat(b[0], b[0] ? 4'd6 : 4'd2, d, (b / 2) == 3);
            if (b % 2 == 1) begin
                repeat (2) begin
                    @(negedge aclk);
                    check("t5_s1_stall", m_rready, 0);
                    tick();
                end
                s1_rready = 1'b1;
                tick();
                s1_rready = 1'b0;
            end else begin
                tick();
            end
        end
        r_idle();
        tick();
        sb_on = 1'b0;
        check("t5_s0_count", got0.size(), 4);
        check("t5_s1_count", got1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got0.size()) check("t5_s0_data", got0[i], exp0[i]);
            if (i < got1.size()) check("t5_s1_data", got1[i], exp1[i]);
        end
        @(negedge aclk);
        check("t5_cnt_done", {dut.u_cnt0.r_count, dut.u_cnt1.r_count}, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read port to memory between two requesters: slave 0 is display scanout (priority) and slave 1 is a general reader (texture/DMA).
- Sits between the display/framebuffer AR/R interface plus the second reader, and the memory interconnect.
- Arbitration is fixed priority with an anti-starvation limit and a per-requester outstanding-burst cap.
- R beats are routed back by a select bit prepended to ARID.

Parameters:
ADDR_WIDTH  32  address width
DATA_WIDTH  32  R data width
ID_WIDTH  4  requester-side ID width; master side is ID_WIDTH+1
MAX_OUTSTANDING  4  max accepted-but-not-completed bursts per requester (>=1)
STARVE_LIMIT  8  consecutive s0 grants while s1 waits before s1 is forced (>=1)

Ports:
aclk  in  1  clock
resetn  in  1  synchronous active-low reset
s0_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  slave 0 AR payload
s0_arvalid  in  1 ; s0_arready  out  1  slave 0 AR handshake
s0_rid  out  ID_WIDTH ; s0_rdata  out  DATA_WIDTH ; s0_rresp  out  2 ; s0_rlast  out  1 ; s0_rvalid  out  1  slave 0 R channel
s0_rready  in  1  slave 0 R ready
s1_* (all of the above)  same directions/widths  slave 1
m_arid  out  ID_WIDTH+1  {sel, s_arid}
m_araddr/arlen/arsize/arburst  out  ADDR_WIDTH/8/3/2  master AR payload
m_arvalid  out  1 ; m_arready  in  1  master AR handshake
m_rid  in  ID_WIDTH+1 ; m_rdata  in  DATA_WIDTH ; m_rresp  in  2 ; m_rlast  in  1 ; m_rvalid  in  1 ; m_rready  out  1  master R channel

Behaviour:
- Reset: m_arvalid=0, m_ar* payload=0, both outstanding counters=0, starve counter=0, s0/s1_arready=0.
- AR output is one registered slot. Slot is "free" when !m_arvalid or (m_arvalid && m_arready). Full throughput: one AR per cycle when m_arready is held high.
- Eligibility: eligX = sX_arvalid && cntX < MAX_OUTSTANDING.
- Grant is combinational, active only when the slot is free:
  - grant1 if elig1 && (!elig0 || starve == STARVE_LIMIT);
  - otherwise grant0 if elig0.
- sX_arready = slot free && grantX && cntX < MAX_OUTSTANDING. At most one arready high per cycle.
- On a grant: next cycle m_arvalid=1, payload loaded from the winner, m_arid = {X, sX_arid}. If slot free and no grant, m_arvalid=0.
- Payload is stable while m_arvalid && !m_arready.
- Starve counter:
  - +1 on a s0 grant while elig1, saturating at STARVE_LIMIT;
  - cleared on any s1 grant;
  - held otherwise.
- Outstanding counters, width $clog2(MAX_OUTSTANDING+1):
  - cntX +1 on the slave-side AR handshake (sX_arvalid && sX_arready);
  - cntX -1 on an R handshake with rlast routed to X;
  - both in the same cycle: unchanged.
  - Never exceeds MAX or goes below 0. A completion at cnt=0 is a protocol error: the counter holds at 0 and an assertion fires.
- R routing is purely combinational, zero latency, no buffering:
  - sel = m_rid[ID_WIDTH];
  - sX_rvalid = m_rvalid && sel==X;
  - sX_rid = m_rid[ID_WIDTH-1:0];
  - rdata/rresp/rlast fan out to both slaves;
  - m_rready = sel ? s1_rready : s0_rready.
- Interleaved R beats from different IDs are allowed. Routing is per beat.
- Simultaneous s0/s1 arvalid with starve below the limit: s0 wins. With starve == STARVE_LIMIT: s1 wins, starve resets to 0.
- Reset mid-burst: all state is dropped. The downstream interconnect is reset together with this block. No pending R traffic is tracked after reset.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - SEL_DISPLAY=0, SEL_GENERIC=1;
  - AXI_BURST_INCR=2'b01;
  - a function computing the counter width from MAX_OUTSTANDING.
- One natural sub-module, axi_rd_outstanding_cnt (inc/dec/full/empty, parameterised MAX), instantiated twice.

Test Plan:
- Single requester: s0 AR araddr=0x01E00000, arlen=15, arid=3, m_arready=1 → m_arvalid the next cycle with m_arid=5'b00011; 16 R beats with m_rid=5'b00011 appear only on s0 and cnt0 returns to 0 after rlast.
- Contention, STARVE_LIMIT=8: s0 and s1 hold arvalid continuously, m_arready=1 → grant order is 8×s0, 1×s1, repeating. s1 is never starved beyond 8 grants.
- Outstanding cap, MAX=4: s1 issues 5 ARs with no R returned → 4 accepted, s1_arready stays 0 for the 5th. After one rlast for s1 it is accepted on the next free slot.
- Backpressure: m_arready=0 for 5 cycles with a request pending → m_arvalid and payload stable, no new slave arready. A second request is accepted in the same cycle m_arready goes high.
- Interleaved R: beats alternate m_rid MSB 0/1, s1_rready=0 → s0 beats pass; m_rready=0 on s1 beats; no beat is lost or duplicated, checked by a scoreboard.
- Reset mid-traffic: resetn=0 for 1 cycle with cnt0=2, m_arvalid=1 → next cycle m_arvalid=0, counters=0, starve=0, and both arready=0 during reset.
